serial_addsub: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 10 +
 rtl/serial_addsub_if.sv | 24 ++
 rtl/serial_addsub_full_adder.sv | 16 +
 rtl/serial_addsub.sv | 117 +++++++++++
 tb/tb_serial_addsub.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic datapath.
package serial_arith_pkg;

  // Sequencer states: waiting for a request, or stepping one bit per clock.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle between a client and the serial adder/subtractor.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, data_a, data_b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, data_a, data_b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_full_adder.sv
// One-bit full adder used as the bit slice of the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Plain combinational sum and majority carry.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first,
// with captured operands, registered carry and a start/busy/done handshake.
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  serial_addsub_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_c;

  // Single bit slice; operands are consumed from bit 0 of the shift registers.
  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // Next-state logic: capture on accepted start, one bit step per SHIFT cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    count_d = count_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry.
          a_d     = bus.data_a;
          b_d     = bus.data_b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          count_d = '0;
          sum_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        if (count_q == LAST) begin
          // carry_q here is the carry into the MSB, fa_c the carry out of it.
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset also aborts an operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed WIDTH=8 vectors, handshake
// and reset corner cases, and random sweeps at WIDTH=2, 16 and 32.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8))  if8  ();
  serial_addsub_if #(.WIDTH(2))  if2  ();
  serial_addsub_if #(.WIDTH(16)) if16 ();
  serial_addsub_if #(.WIDTH(32)) if32 ();

  serial_addsub #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));
  serial_addsub #(.WIDTH(2))  dut2  (.clk(clk), .reset(reset), .bus(if2));
  serial_addsub #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(if16));
  serial_addsub #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: integer add/sub with sign-rule overflow.
  task automatic ref_model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                           input logic sb, output logic [63:0] s, output logic co,
                           output logic ov);
    logic [63:0] mask, a, b, full;
    logic sa, sbb, ss;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    full = sb ? (a + ((~b) & mask) + 64'd1) : (a + b);
    s  = full & mask;
    co = full[w];
    sa = a[w-1];
    sbb = b[w-1];
    ss = s[w-1];
    ov = sb ? ((sa != sbb) && (ss != sa)) : ((sa == sbb) && (ss != sa));
  endtask

  // Runs one WIDTH=8 operation starting at a negedge; returns in the done cycle.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic sb,
                         output logic [7:0] s, output logic co, output logic ov,
                         output int lat, output int busy_cnt);
    int k;
    if8.data_a = a;
    if8.data_b = b;
    if8.sub    = sb;
    if8.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8.start  = 1'b0;
    if8.data_a = ~a;
    if8.data_b = ~b;
    if8.sub    = ~sb;
    k = 0;
    busy_cnt = 0;
    while (!if8.done && k < 40) begin
      if (if8.busy) busy_cnt++;
      @(negedge clk);
      k++;
    end
    lat = if8.done ? k : -1;
    s  = if8.sum;
    co = if8.cout;
    ov = if8.ovf;
  endtask

`define SWEEP(IFC, W, TAG) \
  begin \
    automatic int k; \
    automatic logic [63:0] a, b, es; \
    automatic logic sb, eco, eov; \
    for (int i = 0; i < 1000; i++) begin \
      a  = {$urandom, $urandom}; \
      b  = {$urandom, $urandom}; \
      sb = 1'($urandom_range(0, 1)); \
      ref_model(W, a, b, sb, es, eco, eov); \
      IFC.data_a = a[W-1:0]; \
      IFC.data_b = b[W-1:0]; \
      IFC.sub    = sb; \
      IFC.start  = 1'b1; \
      @(posedge clk); \
      @(negedge clk); \
      IFC.start  = 1'b0; \
      IFC.data_a = ~IFC.data_a; \
      IFC.data_b = ~IFC.data_b; \
      k = 0; \
      while (!IFC.done && k < W + 10) begin \
        @(negedge clk); \
        k++; \
      end \
      check($sformatf("%s_op%0d_latency", TAG, i), 64'(k), 64'(W)); \
      check($sformatf("%s_op%0d_sum", TAG, i), 64'(IFC.sum), es); \
      check($sformatf("%s_op%0d_cout", TAG, i), 64'(IFC.cout), 64'(eco)); \
      check($sformatf("%s_op%0d_ovf", TAG, i), 64'(IFC.ovf), 64'(eov)); \
    end \
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    logic co, ov, seen_done;
    int lat, bc;

    vecs[0] = '{a: 8'h3C, b: 8'h25, sub: 1'b0, sum: 8'h61, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'h05, b: 8'h07, sub: 1'b1, sum: 8'hFE, cout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, sub: 1'b1, sum: 8'h7F, cout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 8'h00, b: 8'h00, sub: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[6] = '{a: 8'h80, b: 8'h80, sub: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};

    if8.start = 0;  if8.sub = 0;  if8.data_a = '0;  if8.data_b = '0;
    if2.start = 0;  if2.sub = 0;  if2.data_a = '0;  if2.data_b = '0;
    if16.start = 0; if16.sub = 0; if16.data_a = '0; if16.data_b = '0;
    if32.start = 0; if32.sub = 0; if32.data_a = '0; if32.data_b = '0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(if8.busy), 64'd0);
    check("reset_done", 64'(if8.done), 64'd0);
    check("reset_sum",  64'(if8.sum),  64'd0);
    check("reset_cout", 64'(if8.cout), 64'd0);
    check("reset_ovf",  64'(if8.ovf),  64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table; consecutive operations are also back-to-back.
    for (int i = 0; i < 7; i++) begin
      run_op8(vecs[i].a, vecs[i].b, vecs[i].sub, s, co, ov, lat, bc);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd8);
      check($sformatf("vec%0d_sum", i),  64'(s),  64'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 64'(co), 64'(vecs[i].cout));
      check($sformatf("vec%0d_ovf", i),  64'(ov), 64'(vecs[i].ovf));
    end

    // done lasts one cycle and the result holds afterwards.
    @(negedge clk);
    check("done_one_cycle", 64'(if8.done), 64'd0);
    check("hold_sum", 64'(if8.sum), 64'h00);
    check("hold_busy", 64'(if8.busy), 64'd0);

    // start during an operation is ignored.
    if8.data_a = 8'h3C; if8.data_b = 8'h25; if8.sub = 1'b0; if8.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    if8.data_a = 8'h11; if8.data_b = 8'h22; if8.sub = 1'b1; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    lat = 4;
    while (!if8.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ignore_latency", 64'(lat), 64'd8);
    check("ignore_sum", 64'(if8.sum), 64'h61);
    check("ignore_cout", 64'(if8.cout), 64'd0);
    @(negedge clk);
    check("ignore_no_second_done", 64'(if8.done), 64'd0);
    check("ignore_not_busy", 64'(if8.busy), 64'd0);

    // Back-to-back from the done cycle of a subtract that sets cout/ovf.
    run_op8(8'h80, 8'h01, 1'b1, s, co, ov, lat, bc);
    run_op8(8'h10, 8'h20, 1'b0, s, co, ov, lat, bc);
    check("b2b_latency", 64'(lat), 64'd8);
    check("b2b_sum", 64'(s), 64'h30);
    check("b2b_cout", 64'(co), 64'd0);

    // Reset after three bit steps, with cout/ovf set beforehand.
    run_op8(8'h80, 8'h01, 1'b1, s, co, ov, lat, bc);
    if8.data_a = 8'hFF; if8.data_b = 8'hFF; if8.sub = 1'b0; if8.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 64'(if8.busy), 64'd0);
    check("midrst_sum",  64'(if8.sum),  64'd0);
    check("midrst_cout", 64'(if8.cout), 64'd0);
    check("midrst_ovf",  64'(if8.ovf),  64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (if8.done) seen_done = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_done", 64'(seen_done), 64'd0);
    run_op8(8'hFF, 8'hFF, 1'b0, s, co, ov, lat, bc);
    check("midrst_fresh_latency", 64'(lat), 64'd8);
    check("midrst_fresh_sum", 64'(s), 64'hFE);
    check("midrst_fresh_cout", 64'(co), 64'd1);
    check("midrst_fresh_ovf", 64'(ov), 64'd0);

    // reset and start together: reset wins.
    @(negedge clk);
    if8.data_a = 8'h01; if8.data_b = 8'h01; if8.sub = 1'b0;
    if8.start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    reset = 1'b0;
    check("rst_start_busy", 64'(if8.busy), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (if8.done || if8.busy) seen_done = 1'b1;
      @(negedge clk);
    end
    check("rst_start_dropped", 64'(seen_done), 64'd0);

    // Random sweeps at other widths, run concurrently.
    fork
      `SWEEP(if2, 2, "w2")
      `SWEEP(if16, 16, "w16")
      `SWEEP(if32, 32, "w32")
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
